// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: fetches, scales and hands GRB words to the serializer, then
// holds the latch gap; supports one-shot, auto-refresh and all-off frames.
module led_frame_sequencer #(
  parameter int NUM_LEDS     = 8,
  parameter int IDX_W        = 3,
  parameter int LATCH_CYCLES = 2500,
  parameter int FRAME_CYCLES = 833333,
  parameter int TMR_W        = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  input  logic             clr,
  input  logic [7:0]       brightness,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [23:0]      rd_data,
  output logic             ser_valid,
  output logic [23:0]      ser_data,
  input  logic             ser_ready,
  input  logic             ser_idle,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPT, SEND, DRAIN, LATCH} stateT;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [TMR_W-1:0] FRAME_LOAD = TMR_W'(FRAME_CYCLES - 1);
  localparam logic [TMR_W-1:0] LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);
  stateT state, stateNext;
  logic [IDX_W-1:0] idx, idxNext;
  logic [23:0] word, wordNext;
  logic [TMR_W-1:0] ptmr, ptmrNext, ltmr, ltmrNext;
  logic clrFrame, clrFrameNext, overrunNext;
  // (c * (brightness+1)) >> 8 keeps 255 as unity gain and 0 as fully off
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
  endfunction
  assign busy       = state != IDLE;
  assign rd_en      = state == FETCH;
  assign rd_addr    = rd_en ? idx : '0;
  assign ser_valid  = state == SEND;
  assign ser_data   = word;
  assign frame_done = state == LATCH && ltmr == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      word     <= '0;
      ptmr     <= '0;
      ltmr     <= '0;
      clrFrame <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= stateNext;
      idx      <= idxNext;
      word     <= wordNext;
      ptmr     <= ptmrNext;
      ltmr     <= ltmrNext;
      clrFrame <= clrFrameNext;
      overrun  <= overrunNext;
    end
  end
  always_comb begin
    stateNext    = state;
    idxNext      = idx;
    wordNext     = word;
    ptmrNext     = ptmr != '0 ? ptmr - 1'b1 : ptmr;
    ltmrNext     = ltmr;
    clrFrameNext = clrFrame;
    overrunNext  = overrun | (busy & run & ptmr == '0);
    case (state)
      IDLE: begin
        if (clr) begin
          clrFrameNext = 1'b1;
          idxNext      = '0;
          ptmrNext     = FRAME_LOAD;
          stateNext    = CAPT;
        end else if (start || (run && ptmr == '0)) begin
          clrFrameNext = 1'b0;
          idxNext      = '0;
          ptmrNext     = FRAME_LOAD;
          overrunNext  = start ? 1'b0 : overrun;
          stateNext    = FETCH;
        end
      end
      FETCH: stateNext = CAPT;
      CAPT: begin
        wordNext  = clrFrame ? 24'd0 : {scale(rd_data[23:16], brightness),
                                        scale(rd_data[15:8], brightness),
                                        scale(rd_data[7:0], brightness)};
        stateNext = SEND;
      end
      SEND: begin
        if (ser_ready) begin
          stateNext = idx == LAST ? DRAIN : (clrFrame ? CAPT : FETCH);
          idxNext   = idx == LAST ? idx : idx + 1'b1;
        end
      end
      DRAIN: begin
        if (ser_idle) begin
          ltmrNext  = LATCH_LOAD;
          stateNext = LATCH;
        end
      end
      LATCH: begin
        ltmrNext     = ltmr != '0 ? ltmr - 1'b1 : ltmr;
        clrFrameNext = ltmr == '0 ? 1'b0 : clrFrame;
        stateNext    = ltmr == '0 ? IDLE : LATCH;
      end
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb_led_frame_sequencer: directed vectors plus hand-written multi-cycle sequences
// for the LED frame sequencer (4 LEDs, 8-cycle latch, 100-cycle refresh).
module tb_led_frame_sequencer;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset, start, run, clr, ser_ready, ser_idle;
  logic rd_en, ser_valid, busy, frame_done, overrun;
  logic [7:0] brightness;
  logic [1:0] rd_addr;
  logic [23:0] rd_data, ser_data;
  logic [23:0] mem [N];
  logic [23:0] pat [N] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
  typedef struct {logic [7:0] br; logic [23:0] pix; logic [23:0] exp;} vecT;
  vecT vecs [7];
  int tests = 0, fails = 0;
  int cyc = 0, rdCount = 0, doneCount = 0, lastDone = 0;
  logic [23:0] got [$];
  int hsT [$];
  int startT [$];

  led_frame_sequencer #(.NUM_LEDS(N), .IDX_W(2), .LATCH_CYCLES(8), .FRAME_CYCLES(100), .TMR_W(20)) dut (
    .clk(clk), .reset(reset), .start(start), .run(run), .clr(clr), .brightness(brightness),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .ser_valid(ser_valid),
    .ser_data(ser_data), .ser_ready(ser_ready), .ser_idle(ser_idle), .busy(busy),
    .frame_done(frame_done), .overrun(overrun));

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= reset ? 24'd0 : (rd_en ? mem[rd_addr] : rd_data);

  always @(negedge clk) begin
    cyc++;
    if (ser_valid && ser_ready) begin
      got.push_back(ser_data);
      hsT.push_back(cyc);
    end
    if (rd_en) begin
      rdCount++;
      if (rd_addr == 2'd0) startT.push_back(cyc);
    end
    if (frame_done) begin
      doneCount++;
      lastDone = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = frame_done;
    end
    check({name, "_done"}, 32'(seen), 1);
    step();
    check({name, "_idle_after"}, 32'(busy), 0);
  endtask

  initial begin
    int base, hb, r0, r1, d0, sb;
    bit seen;
    vecs[0] = '{8'd255, 24'h112233, 24'h112233};
    vecs[1] = '{8'd127, 24'hFF8001, 24'h7F4000};
    vecs[2] = '{8'd0,   24'hFF8001, 24'h000000};
    vecs[3] = '{8'd0,   24'hFFFFFF, 24'h000000};
    vecs[4] = '{8'd128, 24'hFFFFFF, 24'h808080};
    vecs[5] = '{8'd1,   24'hFF0102, 24'h010000};
    vecs[6] = '{8'd254, 24'h0A1464, 24'h091363};
    reset = 1'b1; start = 1'b0; run = 1'b0; clr = 1'b0;
    brightness = 8'd255; ser_ready = 1'b1; ser_idle = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = pat[i];
    repeat (3) step();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_ser_valid", 32'(ser_valid), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_ser_data", 32'(ser_data), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);

    // one-shot frame with latency and spacing
    base = got.size(); hb = hsT.size(); r0 = rdCount; d0 = doneCount;
    pulse_start();
    check("os_rd_en_k1", 32'(rd_en), 1);
    check("os_rd_addr_k1", 32'(rd_addr), 0);
    step();
    check("os_rd_en_k2", 32'(rd_en), 0);
    check("os_valid_k2", 32'(ser_valid), 0);
    step();
    check("os_valid_k3", 32'(ser_valid), 1);
    check("os_data_k3", 32'(ser_data), 32'h112233);
    wait_done("os", 100);
    check("os_words", got.size() - base, 4);
    for (int i = 0; i < N; i++) check($sformatf("os_word%0d", i), 32'(got[base + i]), 32'(pat[i]));
    for (int i = 1; i < N; i++) check($sformatf("os_gap%0d", i), hsT[hb + i] - hsT[hb + i - 1], 3);
    check("os_rd_count", rdCount - r0, 4);
    check("os_done_count", doneCount - d0, 1);
    check("os_latch_gap", lastDone - hsT[hb + 3], 9);

    // scaling table
    for (int v = 0; v < 7; v++) begin
      brightness = vecs[v].br;
      for (int i = 0; i < N; i++) mem[i] = vecs[v].pix;
      base = got.size();
      pulse_start();
      wait_done($sformatf("scale%0d", v), 100);
      check($sformatf("scale%0d_first", v), 32'(got[base]), 32'(vecs[v].exp));
      check($sformatf("scale%0d_last", v), 32'(got[base + 3]), 32'(vecs[v].exp));
    end

    // backpressure on LED 2 plus a held DRAIN
    brightness = 8'd255;
    for (int i = 0; i < N; i++) mem[i] = pat[i];
    ser_idle = 1'b0;
    base = got.size(); r0 = rdCount; d0 = doneCount;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      seen = rd_en && rd_addr == 2'd2;
      if (!seen) step();
    end
    check("bp_fetch2", 32'(seen), 1);
    ser_ready = 1'b0;
    step();
    step();
    r1 = rdCount;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(ser_valid), 1);
      check($sformatf("bp_data%0d", i), 32'(ser_data), 32'h778899);
      check($sformatf("bp_rd_en%0d", i), 32'(rd_en), 0);
      if (i < 4) step();
    end
    ser_ready = 1'b1;
    step();
    check("bp_no_extra_rd", rdCount - r1, 0);
    repeat (20) step();
    check("bp_drain_busy", 32'(busy), 1);
    check("bp_drain_no_done", doneCount - d0, 0);
    ser_idle = 1'b1;
    wait_done("bp", 30);
    for (int i = 0; i < N; i++) check($sformatf("bp_word%0d", i), 32'(got[base + i]), 32'(pat[i]));
    check("bp_rd_count", rdCount - r0, 4);

    // clr beats start
    base = got.size(); r0 = rdCount; d0 = doneCount;
    step();
    clr = 1'b1; start = 1'b1;
    step();
    clr = 1'b0; start = 1'b0;
    check("clr_busy", 32'(busy), 1);
    check("clr_rd_en", 32'(rd_en), 0);
    wait_done("clr", 100);
    check("clr_words", got.size() - base, 4);
    for (int i = 0; i < N; i++) check($sformatf("clr_word%0d", i), 32'(got[base + i]), 0);
    check("clr_no_reads", rdCount - r0, 0);
    repeat (5) step();
    check("clr_start_lost", 32'(busy), 0);
    check("clr_done_count", doneCount - d0, 1);

    // auto-refresh period
    sb = startT.size();
    run = 1'b1;
    for (int i = 0; i < 400 && startT.size() - sb < 3; i++) step();
    check("auto_starts", 32'(startT.size() - sb >= 3), 1);
    check("auto_period1", startT[sb + 1] - startT[sb], 100);
    check("auto_period2", startT[sb + 2] - startT[sb + 1], 100);
    check("auto_no_overrun", 32'(overrun), 0);
    run = 1'b0;
    for (int i = 0; i < 100 && busy; i++) step();
    check("auto_stopped", 32'(busy), 0);

    // overrun with a throttled serializer
    ser_ready = 1'b0;
    run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      step();
      ser_ready = (i % 40) == 39;
      seen = frame_done;
    end
    check("ovr_done", 32'(seen), 1);
    check("ovr_set", 32'(overrun), 1);
    step();
    check("ovr_idle", 32'(busy), 0);
    step();
    check("ovr_restart_rd_en", 32'(rd_en), 1);
    check("ovr_restart_addr", 32'(rd_addr), 0);
    run = 1'b0;
    ser_ready = 1'b1;
    wait_done("ovr_next", 100);
    check("ovr_sticky", 32'(overrun), 1);
    pulse_start();
    check("ovr_cleared", 32'(overrun), 0);
    check("ovr_start_rd_en", 32'(rd_en), 1);
    wait_done("ovr_clr", 100);

    // reset mid-SEND
    ser_ready = 1'b0;
    pulse_start();
    step();
    step();
    check("mid_in_send", 32'(ser_valid), 1);
    reset = 1'b1;
    step();
    check("mid_busy", 32'(busy), 0);
    check("mid_valid", 32'(ser_valid), 0);
    check("mid_overrun", 32'(overrun), 0);
    reset = 1'b0;
    ser_ready = 1'b1;
    base = got.size();
    pulse_start();
    check("mid_restart_rd_en", 32'(rd_en), 1);
    check("mid_restart_addr", 32'(rd_addr), 0);
    wait_done("mid", 100);
    check("mid_first_word", 32'(got[base]), 32'h112233);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Frame-level scheduler for the GRB LED chain.
- Fetches one 24-bit GRB word per LED from the pixel frame buffer and scales it by a global brightness.
- Hands each word to the bit serializer over a valid/ready handshake.
- After the last LED, enforces the latch (reset) gap, then pulses frame_done. Supports one-shot frames, periodic auto-refresh and a clear (all-off) frame.

Parameters:
- NUM_LEDS, 8: LEDs per frame (≥1).
- IDX_W, 3: width of the LED index/read address; 2^IDX_W ≥ NUM_LEDS.
- LATCH_CYCLES, 2500: clk cycles of idle line after the last bit (50 µs at 50 MHz).
- FRAME_CYCLES, 833333: auto-refresh period in clk cycles, measured from frame start.
- TMR_W, 20: width of the latch and frame timers.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-shot frame request (pulse)
- run  in  1  level; auto-refresh every FRAME_CYCLES while high
- clr  in  1  request one all-zero frame; no buffer reads
- brightness  in  8  global scale; 255 = unity
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  IDX_W  LED index being read
- rd_data  in  24  {G,R,B}; valid the cycle after rd_en
- ser_valid  out  1  word offered to serializer
- ser_data  out  24  scaled GRB word
- ser_ready  in  1  serializer accepts word when ser_valid & ser_ready
- ser_idle  in  1  serializer has shifted out all bits
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of latch gap
- overrun  out  1  sticky: period elapsed before frame finished

Behaviour:
- Reset: state IDLE; idx=0, word=0, timers=0, clr_frame=0, overrun=0. All outputs 0.
- Outputs are decoded from registered state and registers only; no input-to-output combinational path.
- States: IDLE, FETCH, CAPT, SEND, DRAIN, LATCH.
- IDLE, priority order (clr > start > auto):
  - clr: clr_frame=1, idx=0, go to CAPT (skip FETCH).
  - start: clr_frame=0, idx=0, go to FETCH.
  - run & ptmr==0: same as start.
  - Entering a frame from IDLE loads ptmr=FRAME_CYCLES-1.
- FETCH: rd_en=1, rd_addr=idx; next state CAPT.
- CAPT: registers word = clr_frame ? 0 : scale(rd_data); next state SEND.
- Scaling, per 8-bit channel c: out = (c*(brightness+1))>>8.
  - 9-bit × 8-bit product, 17 bits wide; take bits [15:8].
  - brightness=255 gives out=c; brightness=0 gives out=c>>8=0 for all c.
- SEND: ser_valid=1, ser_data=word, held stable until ser_ready.
  - On handshake with idx==NUM_LEDS-1: go to DRAIN.
  - Otherwise: idx+1, then FETCH (or CAPT if clr_frame).
- DRAIN: wait for ser_idle=1, then load ltmr=LATCH_CYCLES-1 and go to LATCH.
- LATCH: decrement ltmr. At ltmr==0: frame_done=1 for that cycle, clear clr_frame, next state IDLE.
- Latency: start sampled at edge k.
  - rd_en high in cycle k+1.
  - ser_valid high from cycle k+3.
  - With ser_ready tied high, consecutive words are 3 cycles apart.
- ptmr behaviour:
  - Decrements every cycle while nonzero, in any state; holds at 0.
  - If ptmr reaches 0 while busy and run=1, overrun is set.
  - overrun clears only on reset or on an accepted start.
  - After an overrun, the next frame starts the cycle after returning to IDLE.
- start/clr/run falling while busy: ignored. A frame is never truncated, since a partial frame corrupts the chain. A start pulse arriving while busy is dropped.
- run low in IDLE: ptmr keeps counting down, but no auto frame is issued.
- NUM_LEDS=1: SEND goes directly to DRAIN after the first handshake.
- idx never exceeds NUM_LEDS-1. rd_addr is 0 whenever rd_en=0.
- Reset mid-frame returns to IDLE within one edge and deasserts ser_valid. The serializer is reset by the same signal.

Test Plan:
- Setup for all scenarios: NUM_LEDS=4, LATCH_CYCLES=8, FRAME_CYCLES=100.
- One-shot frame: buffer {0x112233,0x445566,0x778899,0xAABBCC}, brightness=255, ser_ready=1, ser_idle=1.
  - Required: ser_data sequence matches the buffer exactly.
  - frame_done pulses exactly once, 8 cycles after DRAIN exits.
  - busy is low the following cycle.
- Scaling: brightness=127, rd_data=0xFF8001.
  - Required: ser_data=0x7F4000.
  - With brightness=0: 0x000000.
- Backpressure: ser_ready low for 5 cycles during LED 2.
  - Required: ser_data stable and ser_valid held throughout.
  - idx does not advance; no extra rd_en pulses.
- Clear and priority: clr and start asserted together in IDLE.
  - Required: 4 words of 0x000000 and no rd_en pulses.
  - The start pulse is lost.
- Auto-refresh:
  - run=1: frame starts every 100 cycles.
  - With ser_ready throttled so a frame takes 120 cycles: overrun=1, and the next frame starts 1 cycle after frame_done.
  - A subsequent start clears overrun.
- Reset mid-SEND: assert reset.
  - Required: the next cycle has busy=0, ser_valid=0, overrun=0.
  - A new start then begins again at rd_addr=0.
